pc_fetch_ctrl: RTL and testbench
================================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, 32, PC and instruction-memory address width.
REQ-002 Parameter INST_BYTES, 4, PC increment and alignment; legal values 2 or 4.
REQ-003 Parameter FIFO_DEPTH, 4, instruction buffer depth and in-flight limit; power of two, at least 2.
REQ-004 Port clk, in, 1, clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-005 Port rst_n, in, 1, asynchronous active-low reset.
REQ-006 Port start_i, in, 1, start request; acts on a synchronous rising-edge detect.
REQ-007 Port start_pc_i, in, ADDR_W, first fetch address.
REQ-008 Port stall_i, in, 1, blocks new fetch requests.
REQ-009 Port flush_i, in, 1, pipeline flush with redirect.
REQ-010 Port flush_pc_i, in, ADDR_W, flush target.
REQ-011 Port branch_i, in, 1, branch redirect.
REQ-012 Port branch_pc_i, in, ADDR_W, branch target.
REQ-013 Port imem_req_o, out, 1, fetch request.
REQ-014 Port imem_addr_o, out, ADDR_W, fetch address (current PC).
REQ-015 Port imem_gnt_i, in, 1, request accepted this cycle.
REQ-016 Port imem_rvalid_i, in, 1, in-order response valid, at least 1 cycle after grant.
REQ-017 Port imem_rdata_i, in, 32, response instruction.
REQ-018 Port inst_valid_o, out, 1, buffered instruction available.
REQ-019 Port inst_ready_i, in, 1, decode accepts the instruction.
REQ-020 Port inst_o, out, 32, instruction.
REQ-021 Port inst_pc_o, out, ADDR_W, PC of inst_o.
REQ-022 Port pc_misalign_o, out, 1, misaligned-PC exception; level output.

Function
REQ-023 The FSM SHALL have three states: IDLE, FETCH and ERR.
REQ-024 IDLE->FETCH SHALL occur on the start rising edge, with pc <= start_pc_i; a start edge in FETCH or ERR SHALL be ignored.
REQ-025 Redirect priority SHALL be flush > branch > increment; flush and branch SHALL take effect regardless of stall_i.
REQ-026 Any PC load (start, flush or branch) whose target is not a multiple of INST_BYTES SHALL enter ERR and assert pc_misalign_o; no requests SHALL be issued in ERR.
REQ-027 In ERR, a flush with an aligned flush_pc_i SHALL return to FETCH and clear pc_misalign_o; a branch SHALL be ignored in ERR.
REQ-028 imem_req_o SHALL be high only when the FSM is in FETCH, stall_i=0, no redirect is present this cycle, and outstanding+fifo_count < FIFO_DEPTH.
REQ-029 On req&&gnt, pc SHALL advance by INST_BYTES (modulo 2^ADDR_W wrap), the granted pc SHALL be pushed into the pending-PC queue, and outstanding SHALL increment.
REQ-030 The imem side SHALL accept retraction: an ungranted request may drop or change address on the next cycle.
REQ-031 On imem_rvalid_i, outstanding SHALL decrement; when discard=0, {pending PC, rdata} SHALL be pushed into the instruction FIFO.
REQ-032 On flush or branch, both FIFOs SHALL clear, and discard SHALL load outstanding (plus 1 for any same-cycle grant, minus 1 for any same-cycle rvalid); discarded responses SHALL only decrement discard.
REQ-033 inst_valid_o SHALL equal "instruction FIFO not empty" and SHALL be forced low in the cycle of flush or branch; a pop SHALL occur on valid&&ready.
REQ-034 Push and pop of the full FIFO in the same cycle SHALL be legal and leave the count unchanged; credit gating SHALL guarantee the FIFO never overflows.
REQ-035 First-request latency SHALL be 1 cycle after the start edge is detected.

Reset
REQ-036 Asynchronous reset SHALL set state=IDLE and clear pc, outstanding, discard and both FIFOs; imem_req_o, inst_valid_o and pc_misalign_o SHALL be 0.
REQ-037 Reset mid-operation SHALL abandon in-flight responses; the system SHALL reset imem together with this block.

Structure
REQ-038 The shared package SHALL hold the FSM state enum, INST_BYTES legal values and the width function clog2.
REQ-039 One sub-module, sync_fifo (parameters WIDTH, DEPTH), SHALL be instantiated twice: pending-PC queue (ADDR_W) and instruction FIFO (ADDR_W+32).

Verification
REQ-040 Start edge with start_pc_i=0x100, gnt tied 1, rvalid 1 cycle later, ready=1 -> addresses 0x100, 0x104, 0x108; inst_pc_o follows in order.
REQ-041 ready=0 with FIFO_DEPTH=4 -> exactly 4 grants, then imem_req_o=0 until the first pop.
REQ-042 Branch to 0x200 with 2 responses outstanding -> both responses dropped; next inst_pc_o=0x200.
REQ-043 Flush to 0x102 with INST_BYTES=4 -> ERR, pc_misalign_o=1, no requests; a flush to 0x300 -> FETCH, pc_misalign_o=0.
REQ-044 stall_i=1 for 5 cycles with 2 responses outstanding -> both responses buffered, no new requests, pc held.
REQ-045 PC 0xFFFFFFFC granted -> next address 0x00000000; reset asserted mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and helpers for the PC/fetch controller slice.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StErr
  } state_e;

  localparam int unsigned InstBytesHalf = 2;
  localparam int unsigned InstBytesWord = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned acc;
    result = 0;
    acc    = 1;
    while (acc < value) begin
      acc    = acc * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_fifo.sv
// Synchronous FIFO with clear; a push into a full FIFO is accepted only alongside a pop.
module sync_fifo
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  count_o
);

  localparam int unsigned PtrW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             full, push_ok, pop_ok;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC generation and instruction fetch with credit-limited requests and a decode-side buffer.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned INST_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              pc_misalign_o
);

  localparam int unsigned       CntW      = clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(INST_BYTES - 1);
  localparam logic [ADDR_W-1:0] PcStep    = ADDR_W'(INST_BYTES);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CntW-1:0]     outst_q, outst_d, discard_q, discard_d;
  logic                start_q;
  logic                start_edge, flush_act, branch_act, redirect;
  logic                grant, keep_rsp, credit_ok;
  logic [ADDR_W-1:0]   pend_pc;
  logic                pend_empty, inst_empty;
  logic [CntW-1:0]     pend_count, inst_count;
  logic [ADDR_W+31:0]  inst_entry;
  logic                unused_pend;

  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return (addr & AlignMask) != '0;
  endfunction

  assign start_edge = start_i && !start_q;
  assign flush_act  = flush_i && (state_q != StIdle);
  assign branch_act = branch_i && !flush_i && (state_q == StFetch);
  assign redirect   = flush_act || branch_act;

  // Credits cover both in-flight responses and buffered instructions, so the buffer cannot overflow.
  assign credit_ok  = ({1'b0, outst_q} + {1'b0, inst_count}) < (CntW + 1)'(FIFO_DEPTH);
  assign imem_req_o = (state_q == StFetch) && !stall_i && !flush_i && !branch_i && credit_ok;
  assign grant      = imem_req_o && imem_gnt_i;
  assign keep_rsp   = imem_rvalid_i && (discard_q == '0);

  assign imem_addr_o   = pc_q;
  assign pc_misalign_o = (state_q == StErr);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          pc_d    = start_pc_i;
          state_d = misaligned(start_pc_i) ? StErr : StFetch;
        end
      end
      StFetch: begin
        if (flush_i) begin
          pc_d    = flush_pc_i;
          state_d = misaligned(flush_pc_i) ? StErr : StFetch;
        end else if (branch_i) begin
          pc_d    = branch_pc_i;
          state_d = misaligned(branch_pc_i) ? StErr : StFetch;
        end else if (grant) begin
          pc_d = pc_q + PcStep;
        end
      end
      StErr: begin
        if (flush_i && !misaligned(flush_pc_i)) begin
          pc_d    = flush_pc_i;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (grant && !imem_rvalid_i)      outst_d = outst_q + 1'b1;
    else if (!grant && imem_rvalid_i) outst_d = outst_q - 1'b1;
    discard_d = discard_q;
    // Everything still in flight after a redirect belongs to the old stream.
    if (redirect)                                discard_d = outst_d;
    else if (imem_rvalid_i && discard_q != '0)   discard_d = discard_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      start_q   <= start_i;
    end
  end

  sync_fifo #(
    .WIDTH(ADDR_W),
    .DEPTH(FIFO_DEPTH)
  ) u_pend_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect),
    .push_i  (grant),
    .wdata_i (pc_q),
    .pop_i   (keep_rsp),
    .rdata_o (pend_pc),
    .empty_o (pend_empty),
    .count_o (pend_count)
  );

  sync_fifo #(
    .WIDTH(ADDR_W + 32),
    .DEPTH(FIFO_DEPTH)
  ) u_inst_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect),
    .push_i  (keep_rsp),
    .wdata_i ({pend_pc, imem_rdata_i}),
    .pop_i   (inst_valid_o && inst_ready_i),
    .rdata_o (inst_entry),
    .empty_o (inst_empty),
    .count_o (inst_count)
  );

  assign inst_valid_o           = !inst_empty && !redirect;
  assign {inst_pc_o, inst_o}    = inst_valid_o ? inst_entry : '0;
  assign unused_pend            = ^{pend_empty, pend_count};

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomised bench for pc_fetch_ctrl: imem responder, stream-level model and scoreboard monitor.
module tb_pc_fetch_ctrl;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, branch_i = 1'b0;
  logic [31:0] start_pc_i = '0, flush_pc_i = '0, branch_pc_i = '0;
  logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
  logic [31:0] imem_addr_o, imem_rdata_i = '0;
  logic        inst_valid_o, inst_ready_i = 1'b0, pc_misalign_o;
  logic [31:0] inst_o, inst_pc_o;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .ADDR_W(ADDR_W),
    .INST_BYTES(INST_BYTES),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .start_pc_i(start_pc_i), .stall_i(stall_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i), .branch_i(branch_i), .branch_pc_i(branch_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .pc_misalign_o(pc_misalign_o)
  );

  typedef struct { logic [31:0] pc; int epoch; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } inst_t;
  typedef struct { logic [31:0] data; int due; } rsp_t;

  flight_t inflight[$];
  inst_t   expq[$];
  rsp_t    rspq[$];

  int          n_cmp = 0, n_err = 0, cyc = 0, epoch = 0, mode = 0, n_grant = 0;
  logic [31:0] mpc = '0;
  bit          prev_start = 0, popped = 0;
  int unsigned gnt_pct = 100, ready_pct = 100, rv_pct = 100, lat_min = 1, lat_max = 1;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every delivered instruction against the expected stream.
  always @(negedge clk) begin
    popped = 0;
    if (rst_n) begin
      chk("inst_valid", 64'(inst_valid_o), 64'((expq.size() > 0) && !(flush_i || branch_i)));
      if (inst_valid_o && inst_ready_i) begin
        chk("inst_avail", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          chk("inst_pc", 64'(inst_pc_o), 64'(expq[0].pc));
          chk("inst_data", 64'(inst_o), 64'(expq[0].inst));
          void'(expq.pop_front());
          popped = 1;
        end
      end
    end
  end

  // Reference model: fetch stream with epochs; stale-epoch responses are dropped.
  always @(negedge clk) begin
    bit          exp_req;
    int          credit;
    flight_t     f;
    logic [31:0] tgt;
    #1;
    if (!rst_n) begin
      inflight.delete();
      expq.delete();
      mode       = 0;
      mpc        = '0;
      prev_start = 0;
    end else begin
      credit  = inflight.size() + expq.size() + int'(popped);
      exp_req = (mode == 1) && !stall_i && !flush_i && !branch_i && (credit < FIFO_DEPTH);
      chk("imem_req", 64'(imem_req_o), 64'(exp_req));
      chk("pc_misalign", 64'(pc_misalign_o), 64'(mode == 2));
      if (mode == 1) chk("imem_addr", 64'(imem_addr_o), 64'(mpc));
      if (imem_rvalid_i && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (f.epoch == epoch) expq.push_back('{f.pc, hash(f.pc)});
      end
      if (imem_req_o && imem_gnt_i) begin
        n_grant++;
        rspq.push_back('{hash(imem_addr_o), cyc + int'($urandom_range(lat_max, lat_min))});
        if (exp_req) begin
          inflight.push_back('{mpc, epoch});
          mpc = mpc + INST_BYTES;
        end
      end
      if (mode == 1 && (flush_i || branch_i)) begin
        tgt = flush_i ? flush_pc_i : branch_pc_i;
        epoch++;
        expq.delete();
        mpc  = tgt;
        mode = (tgt % INST_BYTES != 0) ? 2 : 1;
      end else if (mode == 2 && flush_i) begin
        epoch++;
        expq.delete();
        if (flush_pc_i % INST_BYTES == 0) begin
          mpc  = flush_pc_i;
          mode = 1;
        end
      end else if (mode == 0 && start_i && !prev_start) begin
        mpc  = start_pc_i;
        mode = (start_pc_i % INST_BYTES != 0) ? 2 : 1;
      end
      prev_start = start_i;
    end
  end

  // Advance one cycle and drive the imem responder and decode ready.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    flush_i       = 1'b0;
    branch_i      = 1'b0;
    start_i       = 1'b0;
    imem_gnt_i    = ($urandom_range(99, 0) < gnt_pct);
    inst_ready_i  = ($urandom_range(99, 0) < ready_pct);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (rspq.size() > 0 && rspq[0].due <= cyc && $urandom_range(99, 0) < rv_pct) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = rspq[0].data;
      void'(rspq.pop_front());
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 64'(imem_req_o), 64'd0);
    chk({tag, "_valid"}, 64'(inst_valid_o), 64'd0);
    chk({tag, "_misalign"}, 64'(pc_misalign_o), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr_o), 64'd0);
    chk({tag, "_inst"}, 64'({inst_pc_o, inst_o}), 64'd0);
  endtask

  task automatic reset_mid_cycle();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    rspq.delete();
    imem_rvalid_i = 1'b0;
    imem_gnt_i    = 1'b0;
    stall_i       = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int g0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Start at 0x100 with single-cycle memory.
    step(); start_pc_i = 32'h100; start_i = 1'b1;
    repeat (12) step();

    // Decode stalled: exactly FIFO_DEPTH grants, then requests stop.
    ready_pct = 0;
    step(); flush_i = 1'b1; flush_pc_i = 32'h400;
    g0 = n_grant;
    repeat (12) step();
    chk("grants_ready0", 64'(n_grant - g0), 64'(FIFO_DEPTH));
    ready_pct = 100;
    repeat (6) step();

    // Branch with two responses in flight.
    lat_min = 6; lat_max = 6;
    step(); flush_i = 1'b1; flush_pc_i = 32'h500;
    repeat (2) step();
    branch_i = 1'b1; branch_pc_i = 32'h200;
    repeat (14) step();

    // Misaligned flush, branch ignored in ERR, aligned flush recovers.
    lat_min = 1; lat_max = 1;
    step(); flush_i = 1'b1; flush_pc_i = 32'h102;
    repeat (4) step();
    branch_i = 1'b1; branch_pc_i = 32'h600;
    repeat (3) step();
    flush_i = 1'b1; flush_pc_i = 32'h300;
    repeat (6) step();

    // Stall with responses outstanding.
    lat_min = 3; lat_max = 3;
    repeat (2) step();
    stall_i = 1'b1;
    repeat (5) step();
    stall_i = 1'b0;
    repeat (6) step();

    // Address wrap.
    lat_min = 1; lat_max = 1;
    step(); flush_i = 1'b1; flush_pc_i = 32'hFFFF_FFF8;
    repeat (8) step();

    // Reset mid-burst, then restart at the top of the address space.
    lat_min = 2; lat_max = 3;
    repeat (3) step();
    reset_mid_cycle();
    step(); start_pc_i = 32'hFFFF_FFFC; start_i = 1'b1;
    repeat (8) step();

    // Randomised traffic.
    gnt_pct = 70; ready_pct = 70; rv_pct = 80; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      step();
      stall_i = ($urandom_range(99, 0) < 20);
      if ($urandom_range(999, 0) < 20) begin
        flush_i    = 1'b1;
        flush_pc_i = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(9, 0) == 0) ? 32'h2 : 32'h0);
      end else if ($urandom_range(999, 0) < 25) begin
        branch_i    = 1'b1;
        branch_pc_i = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(9, 0) == 0) ? 32'h1 : 32'h0);
      end
      if ($urandom_range(999, 0) < 10) begin
        start_i    = 1'b1;
        start_pc_i = $urandom & 32'hFFFF_FFFC;
      end
      if ($urandom_range(999, 0) < 2) reset_mid_cycle();
    end

    // Drain: no new requests, accept everything buffered.
    stall_i = 1'b1; ready_pct = 100; rv_pct = 100; gnt_pct = 100;
    for (int i = 0; i < 100 && (expq.size() > 0 || rspq.size() > 0); i++) step();
    repeat (2) step();
    chk("drain_empty", 64'(expq.size() + rspq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
